// File: rtl/uart_tx_fifo_pkg.sv
// rtl/uart_tx_fifo_pkg.sv - shared types and constants for the UART transmit path
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam int   DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// rtl/uart_tx_fifo_if.sv - producer byte handshake into the UART transmit FIFO
interface uart_tx_fifo_if;

    logic       i_valid;
    logic [7:0] i_byte;
    logic       o_ready;
    logic       o_overflow;

    modport master (
        output i_valid,
        output i_byte,
        input  o_ready,
        input  o_overflow
    );

    modport slave (
        input  i_valid,
        input  i_byte,
        output o_ready,
        output o_overflow
    );

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// rtl/uart_tx_fifo_sync_fifo.sv - single-clock FIFO with occupancy count
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("sync_fifo: DEPTH must be a power of two in 2..16");
    end

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             wr_en;
    logic             rd_en;

    // A full FIFO refuses the write even when a read frees a slot this cycle.
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_en) begin
            wptr_d = wptr_q + AW'(1);
        end
        if (rd_en) begin
            rptr_d = rptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= din;
        end
    end

    assign dout  = mem_q[rptr_q];
    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter for the processed audio stream
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115_200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic           i_clk,
    input  logic           i_rst,
    uart_tx_fifo_if.slave  s_if,
    output logic           o_tx,
    output logic           o_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int BW = (CLKS_PER_BIT < 2) ? 1 : $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ / BAUD_RATE must be at least 2");
    end

    tx_state_t              state_q, state_d;
    logic [BW-1:0]          baud_q, baud_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   tx_q, tx_d;
    logic                   ovf_q, ovf_d;

    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_dout;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CW-1:0]          fifo_count;
    logic                   bit_done;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .push  (s_if.i_valid),
        .pop   (fifo_pop),
        .din   (s_if.i_byte),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bit_done = (baud_q == BAUD_LAST);

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_dout;
                    baud_d   = '0;
                    idx_d    = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                // Chain straight into the next start bit so queued bytes leave no idle gap.
                if (bit_done) begin
                    baud_d = '0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        shift_d  = fifo_dout;
                        idx_d    = '0;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the next state so it changes on the same edge as the FSM.
    always_comb begin
        case (state_d)
            START:   tx_d = START_BIT;
            DATA:    tx_d = shift_d[0];
            default: tx_d = STOP_BIT;
        endcase
    end

    assign ovf_d = s_if.i_valid && fifo_full;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= STOP_BIT;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign s_if.o_ready    = !fifo_full;
    assign s_if.o_overflow = ovf_q;
    assign o_tx            = tx_q;
    assign o_busy          = (state_q != IDLE) || (fifo_count != '0);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for the buffered UART transmitter
module tb_uart_tx_fifo;

    logic i_clk = 1'b0;
    logic i_rst;
    logic o_tx;
    logic o_busy;

    uart_tx_fifo_if bus ();

    uart_tx_fifo #(
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (5_000_000),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .s_if   (bus),
        .o_tx   (o_tx),
        .o_busy (o_busy)
    );

    always #5 i_clk = ~i_clk;

    int         n_checks   = 0;
    int         n_errors   = 0;
    int         cyc        = 0;
    int         n_pushed   = 0;
    int         n_decoded  = 0;
    int         ovf_seen   = 0;
    logic       ovf_watch  = 1'b0;
    logic [7:0] exp_q[$];
    int         start_q[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    always @(negedge i_clk) begin
        if (ovf_watch && bus.o_overflow) ovf_seen++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Decoder: samples each bit mid-period (10 clocks/bit) and drops frames cut by reset.
    initial begin
        logic [7:0] data;
        logic       start_b;
        logic       stop_b;
        logic       aborted;
        logic [7:0] exp_b;
        forever begin
            @(negedge i_clk);
            if (i_rst !== 1'b0 || o_tx !== 1'b0) continue;
            start_q.push_back(cyc);
            aborted = 1'b0;
            start_b = 1'b1;
            stop_b  = 1'b0;
            data    = '0;
            for (int c = 1; c <= 94; c++) begin
                @(negedge i_clk);
                if (i_rst) begin
                    aborted = 1'b1;
                    break;
                end
                if (c == 4) start_b = o_tx;
                if (c >= 14 && c <= 84 && (c - 14) % 10 == 0) data[(c - 14) / 10] = o_tx;
                if (c == 94) stop_b = o_tx;
            end
            if (!aborted) begin
                n_decoded++;
                chk("start_bit", start_b, 1'b0);
                chk("stop_bit", stop_b, 1'b1);
                chk("frame_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    chk("frame_byte", data, exp_b);
                end
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (o_busy !== 1'b0 && n < 3000) begin
            @(negedge i_clk);
            n++;
        end
        chk("idle_timeout", n < 3000, 1'b1);
        repeat (5) @(negedge i_clk);
    endtask

    logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_ovf [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int tx_low;
        i_rst       = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_byte  = 8'h00;
        #1;
        chk("rst_tx", o_tx, 1'b1);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_ready", bus.o_ready, 1'b1);
        chk("rst_overflow", bus.o_overflow, 1'b0);
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        repeat (5) @(negedge i_clk);

        // Single byte 0xA5: start bit one cycle after acceptance, busy for 100 cycles.
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_byte  = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("a5_tx_accept_edge", o_tx, 1'b1);
        chk("a5_busy_accept_edge", o_busy, 1'b1);
        @(negedge i_clk);
        chk("a5_tx_start", o_tx, 1'b0);
        repeat (99) @(negedge i_clk);
        chk("a5_busy_last", o_busy, 1'b1);
        @(negedge i_clk);
        chk("a5_busy_drop", o_busy, 1'b0);
        chk("a5_tx_idle", o_tx, 1'b1);
        wait_idle();

        // Back-to-back 0x00 then 0xFF: frames must abut exactly.
        start_q.delete();
        @(negedge i_clk);
        bus.i_valid = 1'b1;
        bus.i_byte  = 8'h00;
        exp_q.push_back(8'h00);
        @(negedge i_clk);
        bus.i_byte  = 8'hFF;
        exp_q.push_back(8'hFF);
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        wait_idle();
        chk("b2b_frames", start_q.size(), 2);
        if (start_q.size() == 2) chk("b2b_spacing", start_q[1] - start_q[0], 100);

        // Burst of six into depth four, then a push that lands on the STOP->START pop.
        for (int k = 0; k < 6; k++) begin
            @(negedge i_clk);
            if (k > 0) begin
                chk("burst_ready", bus.o_ready, exp_rdy[k-1]);
                chk("burst_overflow", bus.o_overflow, exp_ovf[k-1]);
            end
            bus.i_valid = 1'b1;
            bus.i_byte  = 8'(8'h10 + k);
            if (k < 5) exp_q.push_back(8'(8'h10 + k));
        end
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("burst_ready_full", bus.o_ready, exp_rdy[5]);
        chk("burst_overflow_pulse", bus.o_overflow, exp_ovf[5]);
        @(negedge i_clk);
        chk("burst_overflow_end", bus.o_overflow, 1'b0);
        repeat (94) @(negedge i_clk);
        chk("popfull_ready_before", bus.o_ready, 1'b0);
        bus.i_valid = 1'b1;
        bus.i_byte  = 8'h16;
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        chk("popfull_overflow", bus.o_overflow, 1'b1);
        chk("popfull_ready_after", bus.o_ready, 1'b1);
        @(negedge i_clk);
        chk("popfull_overflow_end", bus.o_overflow, 1'b0);
        wait_idle();

        // Reset mid-frame with three bytes still queued.
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            bus.i_valid = 1'b1;
            bus.i_byte  = 8'(8'h31 + k);
            exp_q.push_back(8'(8'h31 + k));
        end
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        repeat (30) @(negedge i_clk);
        i_rst = 1'b1;
        exp_q.delete();
        #1;
        chk("midrst_tx", o_tx, 1'b1);
        chk("midrst_ready", bus.o_ready, 1'b1);
        chk("midrst_busy", o_busy, 1'b0);
        repeat (2) @(negedge i_clk);
        i_rst  = 1'b0;
        tx_low = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge i_clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0) tx_low++;
        end
        chk("postrst_quiet_cycles", tx_low, 0);

        // Twenty random bytes with random gaps, outstanding bytes kept below four.
        n_pushed  = 0;
        n_decoded = 0;
        ovf_seen  = 0;
        ovf_watch = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int         w;
            logic [7:0] b;
            @(negedge i_clk);
            bus.i_valid = 1'b0;
            repeat ($urandom_range(0, 60)) @(negedge i_clk);
            w = 0;
            while ((n_pushed - n_decoded) >= 4 && w < 5000) begin
                @(negedge i_clk);
                w++;
            end
            if (w >= 5000) chk("wrap_wait_timeout", w, 0);
            @(negedge i_clk);
            b = 8'($urandom);
            bus.i_valid = 1'b1;
            bus.i_byte  = b;
            exp_q.push_back(b);
            n_pushed++;
        end
        @(negedge i_clk);
        bus.i_valid = 1'b0;
        wait_idle();
        ovf_watch = 1'b0;
        chk("wrap_decoded", n_decoded, 20);
        chk("wrap_no_overflow", ovf_seen, 0);

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Output stage that consumes the processed audio byte stream from the clipping effect and serialises it onto the UART TX line in 8N1 format.
A small FIFO absorbs bursts, so producer valid pulses are never lost while a frame is on the wire.
Sits directly downstream of the effect chain, before the board TX pin.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115_200, serial bit rate in baud
FIFO_DEPTH, 4, buffer entries; power of two, 2..16

Ports:
i_clk  input  1  system clock
i_rst  input  1  asynchronous reset, active-high
i_valid  input  1  producer strobe; byte is offered this cycle
i_byte  input  8  byte to transmit
o_ready  output  1  FIFO not full; byte accepted iff i_valid && o_ready at a rising edge
o_overflow  output  1  one-cycle pulse when i_valid is high and o_ready is low (byte dropped)
o_tx  output  1  serial line; idle high
o_busy  output  1  high while a frame is in progress or the FIFO is non-empty

Behaviour:
- One clock (i_clk); reset is asynchronous and active-high (i_rst). All state is in one clock domain.
- Reset values, from assertion of i_rst: o_tx=1, o_busy=0, o_ready=1, o_overflow=0, FIFO empty, FSM=IDLE, counters 0.
- Reset mid-frame: the line returns high immediately and the partial frame is abandoned. The FIFO contents are discarded.
- Bit timing: CLKS_PER_BIT = CLK_FREQ / BAUD_RATE, using integer division.
  - Elaboration must fail if CLKS_PER_BIT < 2.
  - Each bit is held for exactly CLKS_PER_BIT cycles.
  - Baud counter width = $clog2(CLKS_PER_BIT).
- Frame format: start bit (0), then 8 data bits LSB first, then 1 stop bit (1). Frame length = 10*CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and bit index, and go to START.
  - START: o_tx=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: o_tx=shift[0]. At the end of each bit period, shift right and increment the 3-bit index. After index 7 completes, go to STOP.
  - STOP: o_tx=1 for CLKS_PER_BIT cycles. Then, if the FIFO is non-empty, pop directly and go to START (back-to-back frames, no idle gap). Otherwise go to IDLE.
- o_tx is driven from a register; no combinational path from i_byte to o_tx.
- Latency: a byte accepted at edge N into an empty FIFO while IDLE is popped at edge N+1. o_tx falls after edge N+1.
- FIFO rules:
  - o_ready = !full, registered-equivalent; it does not depend on i_valid.
  - Simultaneous push and pop: allowed at any non-full count, and the count is unchanged.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Read and write pointers wrap modulo FIFO_DEPTH. Occupancy uses a count of width $clog2(FIFO_DEPTH)+1.
- o_overflow is registered: it pulses high for one cycle after each refused valid.
- o_busy = (state != IDLE) || (count != 0).

Decomposition:
- Package uart_pkg:
  - typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t
  - localparams START_BIT=1'b0, STOP_BIT=1'b1, DATA_BITS=8
- Sub-module sync_fifo: parameters WIDTH and DEPTH; ports push, pop, din, dout, full, empty, count. Instantiated once.
- uart_tx_fifo contains the FSM, baud counter and shift register.

Test Plan:
- Setup: CLK_FREQ=50_000_000, BAUD_RATE=5_000_000 (10 clks/bit).
- Reset: assert i_rst mid-run with FIFO_DEPTH=4 and 3 bytes queued -> o_tx=1, o_ready=1, o_busy=0 immediately; no further frames after release.
- Single byte: push 0xA5 -> o_tx goes low 1 cycle after acceptance. Bits sampled at mid-period read 0,1,0,1,0,0,1,0,1,1. o_busy drops 100 cycles after the start edge.
- Back-to-back: push 0x00, then 0xFF on consecutive cycles -> two contiguous 100-cycle frames with no idle cycles between the stop bit and the next start bit. Line patterns 0,00000000,1 then 0,11111111,1.
- Full/overflow: push 6 bytes on consecutive cycles (0x10..0x15) with FIFO_DEPTH=4.
  - One byte is popped into the shifter at cycle 2, so 5 are accepted.
  - o_ready falls, and 0x15 produces a single o_overflow pulse.
  - Transmitted sequence: 0x10..0x14.
- Push at full with simultaneous pop: fill the FIFO, then hold i_valid exactly on the STOP->START pop cycle -> byte refused, o_overflow pulses, count goes 4->3.
- Wrap-around: stream 20 random bytes with random gaps, keeping occupancy ≤4 -> decoded output equals input order exactly. Pointers wrap at least 4 times; o_overflow is never asserted.
